fwd_scoreboard: RTL

Parametrised forwarding and hazard unit for the pipelined CPU. It tracks up to DEPTH in-flight register-writing instructions downstream of the rf_read stage. For each of NUM_SRC source operands of the instruction in rf_read, it supplies the youngest in-flight value. When the youngest matching producer's data is not yet available (load-use), it stalls rf_read and inserts a bubble. This replaces per-stage hand-written detectors with one generic shift-register scoreboard.

---
 rtl/fwd_scoreboard.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding and load-use hazard unit. A DEPTH-entry shift register tracks in-flight
// register writers; each rf_read source picks the youngest producer, or stalls if it is not ready.
module fwd_scoreboard #(
   parameter int DATA_W  = 16,
   parameter int REG_AW  = 3,
   parameter int DEPTH   = 3,
   parameter int NUM_SRC = 2,
   parameter int LD_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_issue_valid,
   input  logic [NUM_SRC-1:0]        i_src_en,
   input  logic [NUM_SRC*REG_AW-1:0] i_src_reg,
   input  logic                      i_wr_en,
   input  logic [REG_AW-1:0]         i_wr_reg,
   input  logic                      i_is_ld,
   input  logic                      i_flush,
   input  logic [DATA_W-1:0]         i_ex_data,
   input  logic [DATA_W-1:0]         i_ld_data,
   output logic [NUM_SRC-1:0]        o_fwd_hit,
   output logic [NUM_SRC*DATA_W-1:0] o_fwd_data,
   output logic                      o_stall,
   output logic [15:0]               o_stall_cnt,
   output logic                      o_busy
);

   logic [DEPTH-1:0]  vld_q, wr_q, ld_q, rdy_q;
   logic [DEPTH-1:0]  vld_d, wr_d, ld_d, rdy_d;
   logic [REG_AW-1:0] reg_q  [DEPTH];
   logic [REG_AW-1:0] reg_d  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];
   logic [15:0]       cnt_q, cnt_d;

   logic [DEPTH-1:0]   eff_rdy;
   logic [DATA_W-1:0]  eff_data [DEPTH];
   logic [NUM_SRC-1:0] win_any, win_rdy, stall_req;
   logic [DATA_W-1:0]  win_data [NUM_SRC];
   logic               take;

   // Entry 0 sees the live ALU result; a load at LD_LAT sees the live memory data.
   always_comb begin : effective
      for (int e = 0; e < DEPTH; e++) begin
         eff_rdy[e]  = rdy_q[e];
         eff_data[e] = data_q[e];
         if (e == 0) begin
            eff_rdy[e]  = ~ld_q[e];
            eff_data[e] = i_ex_data;
         end else if (e == LD_LAT && ld_q[e]) begin
            eff_rdy[e]  = 1'b1;
            eff_data[e] = i_ld_data;
         end
      end
   end

   // Scan oldest to youngest so the youngest match overwrites the older ones.
   always_comb begin : match
      win_any = '0;
      win_rdy = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         win_data[k] = '0;
      end
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int e = DEPTH-1; e >= 0; e--) begin
            if (i_issue_valid && i_src_en[k] && vld_q[e] && wr_q[e] &&
                reg_q[e] == i_src_reg[k*REG_AW +: REG_AW]) begin
               win_any[k]  = 1'b1;
               win_rdy[k]  = eff_rdy[e];
               win_data[k] = eff_data[e];
            end
         end
      end
   end

   always_comb begin : fwd_out
      o_fwd_hit  = '0;
      o_fwd_data = '0;
      stall_req  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         o_fwd_hit[k] = win_any[k] & win_rdy[k];
         stall_req[k] = win_any[k] & ~win_rdy[k];
         if (win_any[k] && win_rdy[k]) begin
            o_fwd_data[k*DATA_W +: DATA_W] = win_data[k];
         end
      end
   end

   // A flushed rf_read instruction is dead, so it can never hold the pipe.
   assign o_stall     = (|stall_req) & ~i_flush;
   assign o_busy      = |vld_q;
   assign o_stall_cnt = cnt_q;
   assign take        = i_issue_valid & i_wr_en & ~o_stall & ~i_flush;

   always_comb begin : next_state
      vld_d     = '0;
      wr_d      = '0;
      ld_d      = '0;
      rdy_d     = '0;
      for (int e = 0; e < DEPTH; e++) begin
         reg_d[e]  = '0;
         data_d[e] = '0;
      end
      vld_d[0] = take;
      wr_d[0]  = take;
      ld_d[0]  = take & i_is_ld;
      rdy_d[0] = take & ~i_is_ld;
      reg_d[0] = take ? i_wr_reg : '0;
      // Shifting the effective view captures ALU and load data on the way through.
      for (int e = 1; e < DEPTH; e++) begin
         vld_d[e]  = vld_q[e-1];
         wr_d[e]   = wr_q[e-1];
         ld_d[e]   = ld_q[e-1];
         rdy_d[e]  = eff_rdy[e-1];
         reg_d[e]  = reg_q[e-1];
         data_d[e] = eff_data[e-1];
      end
      cnt_d = cnt_q;
      if (o_stall && cnt_q != 16'hFFFF) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         wr_q  <= '0;
         ld_q  <= '0;
         rdy_q <= '0;
         cnt_q <= '0;
         for (int e = 0; e < DEPTH; e++) begin
            reg_q[e]  <= '0;
            data_q[e] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         wr_q  <= wr_d;
         ld_q  <= ld_d;
         rdy_q <= rdy_d;
         cnt_q <= cnt_d;
         for (int e = 0; e < DEPTH; e++) begin
            reg_q[e]  <= reg_d[e];
            data_q[e] <= data_d[e];
         end
      end
   end

endmodule
